instruction_fetch_unit: RTL and testbench

Instruction fetch stage that sits directly upstream of the IF/ID pipeline register. It owns the program counter and issues single-outstanding word requests to instruction memory over a request/grant/response handshake. Each fetched (pc, instruction) pair goes to IF/ID. When IF/ID is stalled, the pair is held; on an EX-stage branch redirect, in-flight fetches are discarded. When no valid instruction is available, the output is a bubble: pc 0 with `addi x0,x0,0`.

---
 rtl/riscv_fetch_pkg.sv | 20 ++
 rtl/fetch_hold_reg.sv | 46 ++++
 rtl/instruction_fetch_unit.sv | 181 ++++++++++++++++++
 tb/tb_instruction_fetch_unit.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
package riscv_fetch_pkg;

    localparam int XLEN = 32;

    localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;

    typedef enum logic [1:0] {
        REQ  = 2'd0,
        WAIT = 2'd1,
        HOLD = 2'd2,
        HALT = 2'd3
    } fetch_state_t;

    // Sequential fetch address; 32-bit unsigned, wraps silently.
    function automatic logic [XLEN-1:0] next_word_pc(input logic [XLEN-1:0] pc);
        return pc + 32'd4;
    endfunction

endpackage

// File: rtl/fetch_hold_reg.sv
// Holding register for one (pc, instruction) pair while IF/ID is stalled.
// Clear has priority over load.
module fetch_hold_reg
    import riscv_fetch_pkg::*;
(
    input  logic            clk,
    input  logic            rst_n,
    input  logic            load,
    input  logic            clear,
    input  logic [XLEN-1:0] pc_in,
    input  logic [XLEN-1:0] instr_in,
    output logic [XLEN-1:0] pc_out,
    output logic [XLEN-1:0] instr_out
);

    logic [XLEN-1:0] pc_d, pc_q;
    logic [XLEN-1:0] instr_d, instr_q;

    // Next value: clear to a bubble, capture on load, otherwise keep.
    always_comb begin
        pc_d    = pc_q;
        instr_d = instr_q;
        if (clear) begin
            pc_d    = '0;
            instr_d = NOP_INSTR;
        end else if (load) begin
            pc_d    = pc_in;
            instr_d = instr_in;
        end
    end

    // Pair storage.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q    <= '0;
            instr_q <= NOP_INSTR;
        end else begin
            pc_q    <= pc_d;
            instr_q <= instr_d;
        end
    end

    assign pc_out    = pc_q;
    assign instr_out = instr_q;

endmodule

// File: rtl/instruction_fetch_unit.sv
// Instruction fetch stage feeding IF/ID: owns the PC, issues one outstanding
// word request at a time, holds the fetched pair while IF/ID stalls, and
// discards stale responses after an EX redirect.
// Optional feature macro: FETCH_MISALIGN_TRAP_EN (misaligned redirect traps
// into a terminal HALT state and raises sticky fetchMisaligned).
//
// state | meaning
// ------+------------------------------------------------------------
// REQ   | request driven at pc, waiting for grant
// WAIT  | one request outstanding, waiting for response (drop => stale)
// HOLD  | response captured while IF/ID stalled, pair presented
// HALT  | misaligned redirect trap, exits only on reset
module instruction_fetch_unit
    import riscv_fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rstN,
    input  logic        harzardIF_ID_Write,
    input  logic        branchTaken,
    input  logic [31:0] branchTarget,
    output logic        imemReq,
    output logic [31:0] imemAddr,
    input  logic        imemGnt,
    input  logic        imemRvalid,
    input  logic [31:0] imemRdata,
    output logic [31:0] pcOut,
    output logic [31:0] instructionOut,
    output logic        fetchValid
`ifdef FETCH_MISALIGN_TRAP_EN
    ,
    output logic        fetchMisaligned
`endif
);

    fetch_state_t    state_d, state_q;
    logic [XLEN-1:0] pc_d, pc_q;
    logic [XLEN-1:0] req_pc_d, req_pc_q;
    logic            drop_d, drop_q;
    logic            hold_load, hold_clear;
    logic [XLEN-1:0] hold_pc, hold_instr;
    logic [XLEN-1:0] target;
    logic            trap;

`ifdef FETCH_MISALIGN_TRAP_EN
    logic misaligned_d, misaligned_q;

    assign target          = branchTarget;
    assign trap            = branchTaken && (branchTarget[1:0] != 2'b00) && (state_q != HALT);
    assign misaligned_d    = misaligned_q | trap;
    assign fetchMisaligned = misaligned_q;
`else
    // Without the trap, low bits are simply ignored to keep fetches aligned.
    assign target = branchTarget & ~32'h3;
    assign trap   = 1'b0;
`endif

    fetch_hold_reg u_hold (
        .clk       (clk),
        .rst_n     (rstN),
        .load      (hold_load),
        .clear     (hold_clear),
        .pc_in     (req_pc_q),
        .instr_in  (imemRdata),
        .pc_out    (hold_pc),
        .instr_out (hold_instr)
    );

    // Next-state, register updates and outputs; redirect wins over everything.
    always_comb begin
        state_d        = state_q;
        pc_d           = pc_q;
        req_pc_d       = req_pc_q;
        drop_d         = drop_q;
        hold_load      = 1'b0;
        hold_clear     = 1'b0;
        imemReq        = 1'b0;
        imemAddr       = pc_q;
        fetchValid     = 1'b0;
        pcOut          = '0;
        instructionOut = NOP_INSTR;

        case (state_q)
            REQ: begin
                imemReq = 1'b1;
                if (branchTaken) begin
                    pc_d = target;
                    // A grant this cycle used the old address; its data is stale.
                    if (imemGnt) begin
                        req_pc_d = pc_q;
                        drop_d   = 1'b1;
                        state_d  = WAIT;
                    end
                end else if (imemGnt) begin
                    req_pc_d = pc_q;
                    pc_d     = next_word_pc(pc_q);
                    state_d  = WAIT;
                end
            end

            WAIT: begin
                if (branchTaken) begin
                    pc_d = target;
                    if (imemRvalid) begin
                        drop_d  = 1'b0;
                        state_d = REQ;
                    end else begin
                        drop_d = 1'b1;
                    end
                end else if (imemRvalid) begin
                    if (drop_q) begin
                        drop_d  = 1'b0;
                        state_d = REQ;
                    end else begin
                        fetchValid     = 1'b1;
                        pcOut          = req_pc_q;
                        instructionOut = imemRdata;
                        if (harzardIF_ID_Write) begin
                            state_d = REQ;
                        end else begin
                            hold_load = 1'b1;
                            state_d   = HOLD;
                        end
                    end
                end
            end

            HOLD: begin
                if (branchTaken) begin
                    pc_d       = target;
                    hold_clear = 1'b1;
                    state_d    = REQ;
                end else begin
                    fetchValid     = 1'b1;
                    pcOut          = hold_pc;
                    instructionOut = hold_instr;
                    if (harzardIF_ID_Write) begin
                        state_d = REQ;
                    end
                end
            end

            default: begin
                state_d = HALT;
            end
        endcase

        if (trap) begin
            state_d = HALT;
            drop_d  = 1'b0;
        end
    end

    // State and fetch bookkeeping registers.
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            state_q  <= REQ;
            pc_q     <= RESET_PC;
            req_pc_q <= RESET_PC;
            drop_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            req_pc_q <= req_pc_d;
            drop_q   <= drop_d;
        end
    end

`ifdef FETCH_MISALIGN_TRAP_EN
    // Sticky misalignment flag.
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            misaligned_q <= 1'b0;
        end else begin
            misaligned_q <= misaligned_d;
        end
    end
`endif

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Self-checking bench for instruction_fetch_unit: a directed cycle table,
// hand-written reset/wrap sequences, then randomized traffic against a
// stream-level reference model.
module tb_instruction_fetch_unit;

    localparam logic [31:0] RPC = 32'h0000_0100;
    localparam logic [31:0] KEY = 32'hA5A5_0000;
    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rstN = 1'b0;
    logic        wr = 1'b1;
    logic        br = 1'b0;
    logic [31:0] tgt = '0;
    logic        imemReq;
    logic [31:0] imemAddr;
    logic        gnt = 1'b0;
    logic        rvalid = 1'b0;
    logic [31:0] rdata = '0;
    logic [31:0] pcOut;
    logic [31:0] instructionOut;
    logic        fetchValid;
`ifdef FETCH_MISALIGN_TRAP_EN
    logic        fetchMisaligned;
`endif

    int compared = 0;
    int mismatched = 0;

    always #5 clk = ~clk;

    instruction_fetch_unit #(.RESET_PC(RPC)) dut (
        .clk                (clk),
        .rstN               (rstN),
        .harzardIF_ID_Write (wr),
        .branchTaken        (br),
        .branchTarget       (tgt),
        .imemReq            (imemReq),
        .imemAddr           (imemAddr),
        .imemGnt            (gnt),
        .imemRvalid         (rvalid),
        .imemRdata          (rdata),
        .pcOut              (pcOut),
        .instructionOut     (instructionOut),
        .fetchValid         (fetchValid)
`ifdef FETCH_MISALIGN_TRAP_EN
        ,
        .fetchMisaligned    (fetchMisaligned)
`endif
    );

    typedef struct {
        logic        gnt;
        logic        rvalid;
        logic [31:0] rdata;
        logic        wr;
        logic        br;
        logic [31:0] tgt;
        logic        e_req;
        logic [31:0] e_addr;
        logic        e_fv;
        logic [31:0] e_pc;
        logic [31:0] e_instr;
    } vec_t;

    function automatic vec_t mk(logic g, logic rv, logic [31:0] rd, logic w, logic b,
                                logic [31:0] t, logic ereq, logic [31:0] eaddr,
                                logic efv, logic [31:0] epc, logic [31:0] ei);
        vec_t v;
        v.gnt = g; v.rvalid = rv; v.rdata = rd; v.wr = w; v.br = b; v.tgt = t;
        v.e_req = ereq; v.e_addr = eaddr; v.e_fv = efv; v.e_pc = epc; v.e_instr = ei;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic drive_idle();
        gnt = 1'b0; rvalid = 1'b0; rdata = '0; wr = 1'b1; br = 1'b0; tgt = '0;
    endtask

    task automatic do_reset();
        drive_idle();
        rstN = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rstN = 1'b1;
    endtask

    vec_t tbl[$];

    // random-phase model state
    logic [31:0] fetch_ptr, exp_pc, out_addr;
    logic        outstanding;
    int          consumed;

    initial begin
        // Directed cycle table, zero-wait memory returning addr ^ KEY.
        tbl.push_back(mk(1,0,0,        1,0,0,         1,32'h100, 0,0,NOP));
        tbl.push_back(mk(0,1,KEY^32'h100,1,0,0,       0,0,       1,32'h100,KEY^32'h100));
        tbl.push_back(mk(1,0,0,        1,0,0,         1,32'h104, 0,0,NOP));
        tbl.push_back(mk(0,1,KEY^32'h104,1,0,0,       0,0,       1,32'h104,KEY^32'h104));
        tbl.push_back(mk(1,0,0,        1,0,0,         1,32'h108, 0,0,NOP));
        tbl.push_back(mk(0,1,KEY^32'h108,0,0,0,       0,0,       1,32'h108,KEY^32'h108));
        tbl.push_back(mk(0,0,0,        0,0,0,         0,0,       1,32'h108,KEY^32'h108));
        tbl.push_back(mk(0,0,0,        0,0,0,         0,0,       1,32'h108,KEY^32'h108));
        tbl.push_back(mk(0,0,0,        1,0,0,         0,0,       1,32'h108,KEY^32'h108));
        tbl.push_back(mk(1,0,0,        1,0,0,         1,32'h10C, 0,0,NOP));
        tbl.push_back(mk(0,0,0,        1,1,32'h200,   0,0,       0,0,NOP));
        tbl.push_back(mk(0,1,KEY^32'h10C,1,0,0,       0,0,       0,0,NOP));
        tbl.push_back(mk(1,0,0,        1,1,32'h300,   1,32'h200, 0,0,NOP));
        tbl.push_back(mk(0,1,KEY^32'h200,1,0,0,       0,0,       0,0,NOP));
        for (int i = 0; i < 5; i++)
            tbl.push_back(mk(0,0,0,    1,0,0,         1,32'h300, 0,0,NOP));
        tbl.push_back(mk(1,0,0,        1,0,0,         1,32'h300, 0,0,NOP));
        tbl.push_back(mk(0,1,KEY^32'h300,1,0,0,       0,0,       1,32'h300,KEY^32'h300));
        tbl.push_back(mk(0,0,0,        1,1,32'h202,   1,32'h304, 0,0,NOP));
`ifdef FETCH_MISALIGN_TRAP_EN
        tbl.push_back(mk(0,0,0,        1,0,0,         0,0,       0,0,NOP));
`else
        tbl.push_back(mk(0,0,0,        1,0,0,         1,32'h200, 0,0,NOP));
`endif

        do_reset();
        // Reset values, sampled right after release.
        #1;
        check("rst_req", {31'd0, imemReq}, 32'd1);
        check("rst_addr", imemAddr, RPC);
        check("rst_fv", {31'd0, fetchValid}, 32'd0);
        check("rst_pc", pcOut, 32'd0);
        check("rst_instr", instructionOut, NOP);

        foreach (tbl[i]) begin
            @(negedge clk);
            gnt = tbl[i].gnt; rvalid = tbl[i].rvalid; rdata = tbl[i].rdata;
            wr = tbl[i].wr; br = tbl[i].br; tgt = tbl[i].tgt;
            #1;
            check($sformatf("tbl%0d_req", i), {31'd0, imemReq}, {31'd0, tbl[i].e_req});
            if (tbl[i].e_req) check($sformatf("tbl%0d_addr", i), imemAddr, tbl[i].e_addr);
            check($sformatf("tbl%0d_fv", i), {31'd0, fetchValid}, {31'd0, tbl[i].e_fv});
            check($sformatf("tbl%0d_pc", i), pcOut, tbl[i].e_pc);
            check($sformatf("tbl%0d_instr", i), instructionOut, tbl[i].e_instr);
        end
`ifdef FETCH_MISALIGN_TRAP_EN
        check("misaligned_flag", {31'd0, fetchMisaligned}, 32'd1);
        repeat (3) begin
            @(negedge clk); drive_idle(); gnt = 1'b1; #1;
            check("halt_req", {31'd0, imemReq}, 32'd0);
        end
`endif

        // Reset mid-operation with a request outstanding.
        do_reset();
        @(negedge clk);
        gnt = 1'b1;
        @(negedge clk);
        gnt = 1'b0;
        #1;
        check("wait_req", {31'd0, imemReq}, 32'd0);
        rstN = 1'b0;
        #1;
        check("async_rst_req", {31'd0, imemReq}, 32'd1);
        check("async_rst_addr", imemAddr, RPC);
        @(posedge clk);
        @(negedge clk);
        rstN = 1'b1;
        rvalid = 1'b1; rdata = 32'hDEAD_BEEF;
        #1;
        check("stale_rv_fv", {31'd0, fetchValid}, 32'd0);
        check("stale_rv_pc", pcOut, 32'd0);
        @(negedge clk);
        rvalid = 1'b0;
        #1;
        check("stale_rv_req", {31'd0, imemReq}, 32'd1);
        check("stale_rv_addr", imemAddr, RPC);

        // PC wrap at the top of the address space.
        @(negedge clk);
        br = 1'b1; tgt = 32'hFFFF_FFFC;
        @(negedge clk);
        br = 1'b0; gnt = 1'b1;
        #1;
        check("wrap_addr_hi", imemAddr, 32'hFFFF_FFFC);
        @(negedge clk);
        gnt = 1'b0; rvalid = 1'b1; rdata = KEY ^ 32'hFFFF_FFFC;
        #1;
        check("wrap_fv", {31'd0, fetchValid}, 32'd1);
        check("wrap_pc", pcOut, 32'hFFFF_FFFC);
        @(negedge clk);
        rvalid = 1'b0;
        #1;
        check("wrap_addr_lo", imemAddr, 32'h0000_0000);

`ifndef FETCH_MISALIGN_TRAP_EN
        // Randomized traffic against a stream-level model: the granted
        // addresses and the consumed pcs each form a +4 sequence that restarts
        // at every redirect target, and every presented word is its pc ^ KEY.
        do_reset();
        fetch_ptr = RPC; exp_pc = RPC; outstanding = 1'b0; out_addr = '0; consumed = 0;
        for (int cyc = 0; cyc < 4000; cyc++) begin
            @(negedge clk);
            gnt    = ($urandom_range(0, 9) < 6);
            rvalid = outstanding && ($urandom_range(0, 9) < 5);
            rdata  = rvalid ? (out_addr ^ KEY) : $urandom;
            wr     = ($urandom_range(0, 9) < 7);
            br     = ($urandom_range(0, 99) < 6);
            case ($urandom_range(0, 3))
                0:       tgt = 32'hFFFF_FFF0 + $urandom_range(0, 15);
                default: tgt = $urandom;
            endcase
            #1;
            if (imemReq) begin
                check("rnd_addr", imemAddr, fetch_ptr);
                check("rnd_single_outstanding", {31'd0, outstanding}, 32'd0);
            end
            if (br) check("rnd_br_bubble", {31'd0, fetchValid}, 32'd0);
            if (fetchValid) begin
                check("rnd_pc", pcOut, exp_pc);
                check("rnd_instr", instructionOut, exp_pc ^ KEY);
            end else begin
                check("rnd_bubble_pc", pcOut, 32'd0);
                check("rnd_bubble_instr", instructionOut, NOP);
            end
            if (br) begin
                fetch_ptr = tgt & ~32'h3;
                exp_pc    = tgt & ~32'h3;
            end else begin
                if (imemReq && gnt) fetch_ptr = fetch_ptr + 32'd4;
                if (fetchValid && wr) begin
                    exp_pc = exp_pc + 32'd4;
                    consumed++;
                end
            end
            if (rvalid) outstanding = 1'b0;
            if (imemReq && gnt) begin
                outstanding = 1'b1;
                out_addr    = imemAddr;
            end
        end
        compared++;
        if (consumed < 200) begin
            mismatched++;
            $display("FAIL rnd_progress: got %0d consumed expected at least 200", consumed);
        end
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
